// File: rtl/uart_tx_ser_pkg.sv
// uart_tx_ser_pkg
// Shared definitions for the UART transmit path: serializer state
// encodings and 8N1 frame constants. Imported by the FIFO and the
// serializer top level.
package uart_tx_ser_pkg;

  // Serializer states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DATABITS = 8;
  localparam int STOPBITS = 1;

  // Index of the final data bit, sized to match the bit counter.
  localparam logic [2:0] LAST_DATA_BIT = 3'(DATABITS - 1);

endpackage

// File: rtl/uart_tx_ser_if.sv
// uart_tx_ser_if
// Byte-write path between the UART front end and the transmit back end.
//   wr_i     push strobe, one byte per asserted cycle
//   data_i   byte to push
//   full_o   FIFO holds BUFSZ bytes
//   usage_o  bytes currently held (0..BUFSZ)
// master: the front end that pushes bytes; slave: the transmit back end.
interface uart_tx_ser_if #(
  parameter int BUFSZ = 2
);

  logic                    wr_i;
  logic [7:0]              data_i;
  logic                    full_o;
  logic [$clog2(BUFSZ):0]  usage_o;

  modport master (
    output wr_i,
    output data_i,
    input  full_o,
    input  usage_o
  );

  modport slave (
    input  wr_i,
    input  data_i,
    output full_o,
    output usage_o
  );

endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo
// Small byte FIFO with registered usage and full flags. Shared by the
// transmit and receive paths.
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset; flushes the FIFO
//   wr_i     push strobe (ignored while full)
//   data_i   byte to push
//   rd_i     pop strobe (ignored while empty)
//   data_o   head byte, valid while usage_o != 0
//   full_o   registered, usage_o == BUFSZ
//   usage_o  registered byte count
module uart_byte_fifo
  import uart_tx_ser_pkg::*;
#(
  parameter int BUFSZ = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_i,
  input  logic [DATABITS-1:0]       data_i,
  input  logic                      rd_i,
  output logic [DATABITS-1:0]       data_o,
  output logic                      full_o,
  output logic [$clog2(BUFSZ):0]    usage_o
);

  localparam int PW = $clog2(BUFSZ);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(BUFSZ);

  logic [DATABITS-1:0] mem [BUFSZ];
  logic [PW-1:0]       wptr_q;
  logic [PW-1:0]       rptr_q;
  logic [PW:0]         usage_q;
  logic [PW:0]         usage_d;
  logic                full_q;
  logic                push;
  logic                pop;

  assign push    = wr_i && !full_q;
  assign pop     = rd_i && (usage_q != '0);
  assign data_o  = mem[rptr_q];
  assign full_o  = full_q;
  assign usage_o = usage_q;

  // A simultaneous push and pop leaves the count unchanged.
  always_comb begin
    usage_d = usage_q;
    case ({push, pop})
      2'b10:   usage_d = usage_q + 1'b1;
      2'b01:   usage_d = usage_q - 1'b1;
      default: usage_d = usage_q;
    endcase
  end

  // Pointers wrap naturally at PW bits; full is registered from the
  // next count so it tracks usage_o cycle for cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      usage_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      usage_q <= usage_d;
      full_q  <= (usage_d == FULL_COUNT);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_ser.sv
// uart_tx_ser
// UART transmit back end: buffers bytes in a FIFO and serialises them as
// 8N1 frames with a run-time programmable bit period.
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset
//   bus       byte-write path (wr_i, data_i, full_o, usage_o)
//   clkdiv_i  bit period minus one, latched at each frame start
//   tx_o      registered serial line, idles high
//   idle_o    FIFO empty and no frame in flight
module uart_tx_ser
  import uart_tx_ser_pkg::*;
#(
  parameter int BUFSZ       = 2,
  parameter int CLKDIVBITSZ = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  uart_tx_ser_if.slave           bus,
  input  logic [CLKDIVBITSZ-1:0] clkdiv_i,
  output logic                   tx_o,
  output logic                   idle_o
);

  tx_state_e               state_q;
  tx_state_e               state_d;
  logic                    pop;
  logic                    tx_d;
  logic [DATABITS-1:0]     fifo_data;
  logic [DATABITS-1:0]     shift_q;
  logic [CLKDIVBITSZ-1:0]  period_q;
  logic [CLKDIVBITSZ-1:0]  cnt_q;
  logic [2:0]              bit_q;
  logic                    tick;
  logic                    have_data;

  uart_byte_fifo #(
    .BUFSZ (BUFSZ)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_i    (bus.wr_i),
    .data_i  (bus.data_i),
    .rd_i    (pop),
    .data_o  (fifo_data),
    .full_o  (bus.full_o),
    .usage_o (bus.usage_o)
  );

  assign have_data = (bus.usage_o != '0);
  assign tick      = (cnt_q == '0);
  assign idle_o    = (state_q == ST_IDLE) && !have_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (have_data) state_d = ST_START;
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA:  if (tick && (bit_q == LAST_DATA_BIT)) state_d = ST_STOP;
      ST_STOP:  if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Line level is decoded from the current state and registered below,
  // so tx_o trails the state by one cycle and never glitches.
  always_comb begin
    pop  = 1'b0;
    tx_d = 1'b1;
    case (state_q)
      ST_IDLE:  pop  = have_data;
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      ST_STOP:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // Bit-period counter counts down from the divisor latched at the pop;
  // a divisor change only reaches the line at the next frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_o     <= 1'b1;
      shift_q  <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
    end else begin
      tx_o <= tx_d;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            shift_q  <= fifo_data;
            period_q <= clkdiv_i;
            cnt_q    <= clkdiv_i;
          end
        end
        ST_START: begin
          if (tick) begin
            cnt_q <= period_q;
            bit_q <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DATA: begin
          if (tick) begin
            cnt_q   <= period_q;
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_STOP: begin
          if (!tick) cnt_q <= cnt_q - 1'b1;
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

endmodule
